// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline controller for the 5-stage core. Each cycle it decides which
//   pipeline latches advance (enable) or are squashed (flush), and whether
//   the PC is written. Hazards are resolved in a fixed priority:
//   halted > draining > halt in MEM > memory wait > taken branch >
//   load-use > jump > fetch miss. A halt in MEM starts a short drain so
//   the halt's own writeback retires before the core locks up.
//
// Parameters
//   DRAIN_CYCLES  cycles spent in DRAIN before HALTED (>= 1)
//   CNT_W         width of the stall counter
//
// Ports
//   CLK, nRST           clock (rising edge), async active-low reset
//   ihit, dhit          fetch / data access complete this cycle
//   dREN_mem, dWEN_mem  load / store in MEM
//   dREN_ex, wsel_ex    load in EX and its destination register
//   Rs_id, Rt_id        source registers of the ID instruction
//   branch_ex           taken branch resolved in EX
//   jump_id             jump decoded in ID
//   halt_mem            halt instruction in MEM
//   pc_en               PC write enable
//   <latch>_en/_flush   per-latch enable and flush (IF_ID, ID_EX, EX_MEM, MEM_WB)
//   halted              core halted, held until reset
//   stall_cnt           saturating count of RUN/MEMWAIT cycles with pc_en=0
module hazard_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             dREN_ex,
    input  logic [4:0]       wsel_ex,
    input  logic [4:0]       Rs_id,
    input  logic [4:0]       Rt_id,
    input  logic             branch_ex,
    input  logic             jump_id,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_ctr_q, drain_ctr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Ungated control values; the reset gating is applied at the ports.
    logic pc_c, halted_c;
    logic ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_fl_c, idex_fl_c, exmem_fl_c, memwb_fl_c;

    logic mem_wait, load_use, stall_inc;

    assign mem_wait = (dREN_mem | dWEN_mem) & ~dhit;
    // r0 is hardwired zero, so a load targeting it never creates a hazard.
    assign load_use = dREN_ex & (wsel_ex != 5'd0) &
                      ((wsel_ex == Rs_id) | (wsel_ex == Rt_id));

    always_comb begin
        state_d     = state_q;
        drain_ctr_d = drain_ctr_q;
        pc_c        = ihit;
        halted_c    = 1'b0;
        ifid_en_c   = 1'b1;
        idex_en_c   = 1'b1;
        exmem_en_c  = 1'b1;
        memwb_en_c  = 1'b1;
        ifid_fl_c   = 1'b0;
        idex_fl_c   = 1'b0;
        exmem_fl_c  = 1'b0;
        memwb_fl_c  = 1'b0;

        case (state_q)
            HALTED: begin
                pc_c       = 1'b0;
                halted_c   = 1'b1;
                ifid_en_c  = 1'b0;
                idex_en_c  = 1'b0;
                exmem_en_c = 1'b0;
                memwb_en_c = 1'b0;
            end
            DRAIN: begin
                // Younger stages are squashed; only MEM_WB keeps retiring.
                pc_c        = 1'b0;
                ifid_fl_c   = 1'b1;
                idex_fl_c   = 1'b1;
                exmem_fl_c  = 1'b1;
                drain_ctr_d = drain_ctr_q + 1'b1;
                if (drain_ctr_q == DRAIN_LAST)
                    state_d = HALTED;
            end
            default: begin  // RUN, MEMWAIT
                if (halt_mem) begin
                    // EX_MEM still advances so the halt itself reaches MEM_WB.
                    pc_c        = 1'b0;
                    ifid_fl_c   = 1'b1;
                    idex_fl_c   = 1'b1;
                    state_d     = DRAIN;
                    drain_ctr_d = '0;
                end else if (mem_wait) begin
                    // Freeze everything; a branch in EX is held until dhit.
                    pc_c       = 1'b0;
                    ifid_en_c  = 1'b0;
                    idex_en_c  = 1'b0;
                    exmem_en_c = 1'b0;
                    memwb_en_c = 1'b0;
                    state_d    = MEMWAIT;
                end else begin
                    state_d = RUN;
                    if (branch_ex) begin
                        // Redirect regardless of fetch status; squash IF and ID.
                        pc_c      = 1'b1;
                        ifid_fl_c = 1'b1;
                        idex_fl_c = 1'b1;
                    end else if (load_use) begin
                        pc_c      = 1'b0;
                        ifid_en_c = 1'b0;
                        idex_fl_c = 1'b1;
                    end else if (jump_id) begin
                        ifid_fl_c = 1'b1;
                    end else if (!ihit) begin
                        pc_c      = 1'b0;
                        ifid_fl_c = 1'b1;
                    end
                end
            end
        endcase

        stall_inc   = ((state_q == RUN) || (state_q == MEMWAIT)) && !pc_c;
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            drain_ctr_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_ctr_q <= drain_ctr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Everything is forced low while reset is held, independent of the clock.
    assign pc_en       = nRST & pc_c;
    assign ifid_en     = nRST & ifid_en_c;
    assign ifid_flush  = nRST & ifid_fl_c;
    assign idex_en     = nRST & idex_en_c;
    assign idex_flush  = nRST & idex_fl_c;
    assign exmem_en    = nRST & exmem_en_c;
    assign exmem_flush = nRST & exmem_fl_c;
    assign memwb_en    = nRST & memwb_en_c;
    assign memwb_flush = nRST & memwb_fl_c;
    assign halted      = nRST & halted_c;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, dhit = 1'b0, dREN_mem = 1'b0, dWEN_mem = 1'b0, dREN_ex = 1'b0;
    logic [4:0] wsel_ex = '0, Rs_id = '0, Rt_id = '0;
    logic branch_ex = 1'b0, jump_id = 1'b0, halt_mem = 1'b0;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
    logic [15:0] stall_cnt;
    logic pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2;
    logic exmem_en2, exmem_flush2, memwb_en2, memwb_flush2, halted2;
    logic [1:0] stall_cnt2;

    always #5 CLK = ~CLK;

    hazard_sequencer #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
        .wsel_ex(wsel_ex), .Rs_id(Rs_id), .Rt_id(Rt_id),
        .branch_ex(branch_ex), .jump_id(jump_id), .halt_mem(halt_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    hazard_sequencer #(.DRAIN_CYCLES(2), .CNT_W(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
        .wsel_ex(wsel_ex), .Rs_id(Rs_id), .Rt_id(Rt_id),
        .branch_ex(branch_ex), .jump_id(jump_id), .halt_mem(halt_mem),
        .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2),
        .idex_en(idex_en2), .idex_flush(idex_flush2),
        .exmem_en(exmem_en2), .exmem_flush(exmem_flush2),
        .memwb_en(memwb_en2), .memwb_flush(memwb_flush2),
        .halted(halted2), .stall_cnt(stall_cnt2)
    );

    // Output vector: {pc, ifid_en, ifid_fl, idex_en, idex_fl,
    //                 exmem_en, exmem_fl, memwb_en, memwb_fl, halted}
    localparam logic [9:0] ZERO = 10'b0_00_00_00_00_0;
    localparam logic [9:0] DEF  = 10'b1_10_10_10_10_0;
    localparam logic [9:0] LU   = 10'b0_00_11_10_10_0;
    localparam logic [9:0] MW   = 10'b0_00_00_00_00_0;
    localparam logic [9:0] BR   = 10'b1_11_11_10_10_0;
    localparam logic [9:0] JMP  = 10'b1_11_10_10_10_0;
    localparam logic [9:0] NOIH = 10'b0_11_10_10_10_0;
    localparam logic [9:0] HLTM = 10'b0_11_11_10_10_0;
    localparam logic [9:0] DRN  = 10'b0_11_11_11_10_0;
    localparam logic [9:0] HLT  = 10'b0_00_00_00_00_1;

    typedef struct {
        string       name;
        logic [9:0]  exp;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = '0;

    // Monitor: outputs are settled mid-cycle; compare against the queued expectation.
    always @(negedge CLK) begin
        exp_t e;
        logic [9:0] act, act2;
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            act  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en, memwb_flush, halted};
            act2 = {pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2,
                    exmem_en2, exmem_flush2, memwb_en2, memwb_flush2, halted2};
            checks += 4;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s ctrl: got %b want %b", e.name, act, e.exp);
            end
            if (act2 !== e.exp) begin
                errors++;
                $display("FAIL %s ctrl2: got %b want %b", e.name, act2, e.exp);
            end
            if (stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
            end
            if (stall_cnt2 !== e.cnt2) begin
                errors++;
                $display("FAIL %s stall_cnt2: got %0d want %0d", e.name, stall_cnt2, e.cnt2);
            end
        end
    end

    // Drive one cycle of inputs and queue what the DUT must show this cycle.
    task automatic vec(input string nm, input logic nr, input logic ih, input logic dh,
                       input logic drm, input logic dwm, input logic dre,
                       input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic jp, input logic hl,
                       input logic [9:0] ex);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST = nr; ihit = ih; dhit = dh; dREN_mem = drm; dWEN_mem = dwm;
        dREN_ex = dre; wsel_ex = ws; Rs_id = rs; Rt_id = rt;
        branch_ex = br; jump_id = jp; halt_mem = hl;
        if (!nr) exp_cnt = '0;
        e.name = nm;
        e.exp  = ex;
        e.cnt  = exp_cnt;
        e.cnt2 = (exp_cnt > 16'd3) ? 2'd3 : exp_cnt[1:0];
        sb.push_back(e);
        // Stalls count only outside DRAIN/HALTED and only while out of reset.
        if (nr && !ex[9] && ex != DRN && ex != HLT) exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        //   name            nr ih dh drm dwm dre ws rs rt br jp hl  exp
        vec("reset",         0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
        vec("default",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
        vec("load_use_rt",   1, 1, 0, 0, 0, 1, 3, 1, 3, 0, 0, 0, LU);
        vec("after_lu",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
        vec("load_use_rs",   1, 1, 0, 0, 0, 1, 7, 7, 2, 0, 0, 0, LU);
        vec("load_r0",       1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, DEF);
        vec("load_no_dep",   1, 1, 0, 0, 0, 1, 4, 5, 6, 0, 0, 0, DEF);
        vec("memwait1",      1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MW);
        vec("memwait2",      1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MW);
        vec("memwait3",      1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MW);
        vec("mem_done",      1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
        vec("br_lu_noihit",  1, 0, 0, 0, 0, 1, 3, 0, 3, 1, 0, 0, BR);
        vec("mw_beats_br",   1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, MW);
        vec("br_after_dhit", 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, BR);
        vec("jump",          1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, JMP);
        vec("jump_noihit",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NOIH);
        vec("br_beats_jump", 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, BR);
        vec("lu_beats_jump", 1, 1, 0, 0, 0, 1, 9, 9, 0, 0, 1, 0, LU);
        vec("noihit",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOIH);
        vec("halt_mem",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, HLTM);
        vec("drain1",        1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, DRN);
        vec("drain2",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DRN);
        for (int i = 0; i < 10; i++)
            vec("halted",    1, 1, 1, 1, 0, 1, 3, 3, 3, 1, 1, 1, HLT);
        vec("rst_halted",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
        vec("run_again",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
        vec("mw_then_halt",  1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MW);
        vec("halt_in_mw",    1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, HLTM);
        vec("drain_a",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DRN);
        vec("rst_mid_drain", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
        vec("rst_hold",      0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, ZERO);
        vec("post_rst",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
        for (int i = 0; i < 5; i++)
            vec("sat_noihit", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOIH);
        vec("sat_final",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain_scoreboard: %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
